// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS main control FSM; define MEM_WAIT_EN to honour mem_ready stalls
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNot,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       pcreg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic       SignExtend,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_RTEX    = 4'd7,
    S_ALUWB   = 4'd8,
    S_IMMEX   = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_e;
  state_e state_q, state_d;
  logic   mr;
`ifdef MEM_WAIT_EN
  assign mr = mem_ready;
`else
  // without wait support every memory access is treated as completing immediately
  assign mr = mem_ready | 1'b1;
`endif
  assign state = state_q;
  always_ff @(posedge clk)
    state_q <= reset ? S_RESET : state_d;
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNot   = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    pcreg       = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 4'b0000;
    SignExtend  = 1'b0;
    PCSource    = 2'b00;
    illegal_op  = 1'b0;
    state_d     = S_RESET;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mr;
        PCWrite = mr;
        state_d = mr ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        SignExtend = 1'b1;
        case (Op)
          6'h23, 6'h2B:                             state_d = S_MEMADR;
          6'h00:                                    state_d = S_RTEX;
          6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F: state_d = S_IMMEX;
          6'h04, 6'h05:                             state_d = S_BRANCH;
          6'h02, 6'h03:                             state_d = S_JUMP;
          default:                                  state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        SignExtend = 1'b1;
        state_d    = (Op == 6'h2B) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = mr ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = mr ? S_FETCH : S_MEMWR;
      end
      S_RTEX: begin
        ALUSrcA = 1'b1;
        ALUOp   = 4'b1000;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = (Op == 6'h00);
        state_d  = S_FETCH;
      end
      S_IMMEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUOp      = (Op == 6'h0C) ? 4'b0010 :
                     (Op == 6'h0D) ? 4'b0011 :
                     (Op == 6'h0E) ? 4'b0101 :
                     (Op == 6'h0F) ? 4'b0111 : 4'b0001;
        SignExtend = (Op == 6'h08) || (Op == 6'h0F);
        state_d    = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = (Op == 6'h05) ? 4'b0110 : 4'b0100;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        BranchNot   = (Op == 6'h05);
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        RegWrite = (Op == 6'h03);
        pcreg    = (Op == 6'h03);
        state_d  = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal_op = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_RESET;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench; instruction-level model predicts the per-cycle control word
module tb_multicycle_control;
`ifdef MEM_WAIT_EN
  localparam bit WAIT = 1'b1;
`else
  localparam bit WAIT = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Op = 6'h00;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, BranchNot, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegWrite, RegDst, pcreg, ALUSrcA, SignExtend, illegal_op;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALUOp, state;
  logic [25:0] act;
  logic [25:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNot(BranchNot),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst), .pcreg(pcreg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .SignExtend(SignExtend),
    .PCSource(PCSource), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  assign act = {PCWrite, PCWriteCond, BranchNot, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegWrite, RegDst, pcreg, ALUSrcA, ALUSrcB, ALUOp,
                SignExtend, PCSource, illegal_op, state};

  // control word expected while the instruction is in phase ph
  function automatic logic [25:0] expect_out(int ph, logic [5:0] op, logic mr);
    logic eff, pcw, pcc, bn, iord, mrd, mwr, irw, m2r, rw, rd, pcr, asa, se, ill;
    logic [1:0] asb, pcs;
    logic [3:0] aop, st;
    eff = WAIT ? mr : 1'b1;
    {pcw, pcc, bn, iord, mrd, mwr, irw, m2r, rw, rd, pcr, asa, se, ill} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 4'b0000;
    st = ph[3:0];
    case (ph)
      1:  begin mrd = 1; asb = 2'b01; irw = eff; pcw = eff; end
      2:  begin asb = 2'b11; se = 1; end
      3:  begin asa = 1; asb = 2'b10; se = 1; end
      4:  begin mrd = 1; iord = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mwr = 1; iord = 1; end
      7:  begin asa = 1; aop = 4'b1000; end
      8:  begin rw = 1; rd = (op == 6'h00); end
      9:  begin
        asa = 1; asb = 2'b10;
        aop = op == 6'h0C ? 4'd2 : op == 6'h0D ? 4'd3 : op == 6'h0E ? 4'd5 : op == 6'h0F ? 4'd7 : 4'd1;
        se = (op == 6'h08) || (op == 6'h0F);
      end
      10: begin asa = 1; aop = (op == 6'h05) ? 4'b0110 : 4'b0100; pcc = 1; pcs = 2'b01; bn = (op == 6'h05); end
      11: begin pcw = 1; pcs = 2'b10; rw = (op == 6'h03); pcr = (op == 6'h03); end
      12: ill = 1;
      default: ;
    endcase
    return {pcw, pcc, bn, iord, mrd, mwr, irw, m2r, rw, rd, pcr, asa, asb, aop, se, pcs, ill, st};
  endfunction

  task automatic do_cycle(int ph, logic [5:0] op, logic mr, logic rst);
    reset = rst;
    Op = op;
    mem_ready = mr;
    exp_q.push_back(expect_out(ph, op, mr));
    @(posedge clk);
    #1;
  endtask

  // memory phase: nlow forced stall cycles, then random (rnd) or immediate completion
  task automatic mem_phase(int ph, logic [5:0] op, int nlow, bit rnd);
    logic mr;
    for (int k = 0; k < 64; k++) begin
      mr = (k < nlow) ? 1'b0 : rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      do_cycle(ph, op, mr, 1'b0);
      if (mr || !WAIT) break;
    end
  endtask

  task automatic run_instr(logic [5:0] op, int nlow, bit rnd);
    mem_phase(1, op, 0, rnd);
    do_cycle(2, op, $urandom_range(0, 1), 1'b0);
    case (op)
      6'h23: begin do_cycle(3, op, 1'b0, 1'b0); mem_phase(4, op, nlow, rnd); do_cycle(5, op, 1'b0, 1'b0); end
      6'h2B: begin do_cycle(3, op, 1'b1, 1'b0); mem_phase(6, op, nlow, rnd); end
      6'h00: begin do_cycle(7, op, 1'b0, 1'b0); do_cycle(8, op, 1'b1, 1'b0); end
      6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F:
             begin do_cycle(9, op, 1'b0, 1'b0); do_cycle(8, op, 1'b0, 1'b0); end
      6'h04, 6'h05: do_cycle(10, op, 1'b0, 1'b0);
      6'h02, 6'h03: do_cycle(11, op, 1'b1, 1'b0);
      default: do_cycle(12, op, 1'b0, 1'b0);
    endcase
  endtask

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (exp_q.size() > 0) begin
      logic [25:0] e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL ctrl_word cycle %0d state %0d: got %h expected %h", cyc, e[3:0], act, e);
      end
    end
  end

  initial begin
    logic [5:0] legal[13];
    logic [5:0] op;
    legal = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h04, 6'h05, 6'h02, 6'h03};
    @(posedge clk);
    #1;
    do_cycle(0, 6'h00, 1'b0, 1'b1);
    do_cycle(0, 6'h00, 1'b0, 1'b0);
    run_instr(6'h00, 0, 1'b0);
    run_instr(6'h23, 2, 1'b0);
    run_instr(6'h05, 0, 1'b0);
    run_instr(6'h04, 0, 1'b0);
    run_instr(6'h03, 0, 1'b0);
    run_instr(6'h02, 0, 1'b0);
    run_instr(6'h3F, 0, 1'b0);
    run_instr(6'h2B, 1, 1'b0);
    foreach (legal[i]) run_instr(legal[i], 0, 1'b0);
    for (int n = 0; n < 200; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal[$urandom_range(0, 12)];
      run_instr(op, $urandom_range(0, 1), 1'b1);
    end
    // reset landing in a store's wait cycle
    do_cycle(1, 6'h2B, 1'b1, 1'b0);
    do_cycle(2, 6'h2B, 1'b1, 1'b0);
    do_cycle(3, 6'h2B, 1'b1, 1'b0);
    do_cycle(6, 6'h2B, 1'b0, 1'b1);
    do_cycle(0, 6'h2B, 1'b0, 1'b1);
    do_cycle(0, 6'h2B, 1'b0, 1'b0);
    run_instr(6'h00, 0, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle main control FSM for the MIPS core. It sequences the shared ALU, unified instruction/data memory port, register file and PC through fetch, decode, execute, memory and writeback cycles, one instruction at a time. Opcodes decode with the same ALUOp encoding as the single-cycle control decoder, so the existing ALU control block is reused unchanged. It sits between the instruction register's opcode field and the multi-cycle datapath muxes and enables.

## Interface
- No parameters.
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- Op  in  6  opcode from instruction register (IR[31:26]); stable from DECODE onward
- mem_ready  in  1  memory handshake; access completes in a cycle where it is high
- PCWrite, PCWriteCond, BranchNot  out  1 each  PC update enables; BranchNot=1 selects bne polarity
- IorD, MemRead, MemWrite, IRWrite  out  1 each  memory address select (1=ALUOut) and strobes
- MemtoReg, RegWrite, RegDst, pcreg  out  1 each  writeback control; pcreg=1 writes PC+4 to $31
- ALUSrcA  out  1  0=PC, 1=rs
- ALUSrcB  out  2  00=rt, 01=const 4, 10=ext imm, 11=ext imm<<2
- ALUOp  out  4  0000 add, 1000 R-type, 0100 beq, 0110 bne, 0001 addi/addiu, 0010 andi, 0011 ori, 0101 xori, 0111 lui
- SignExtend  out  1  1=sign, 0=zero extend immediate
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- state  out  4  current state, for debug

## Operation
- States (encoding): RESET 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, RTEX 7, ALUWB 8, IMMEX 9, BRANCH 10, JUMP 11, ILLEGAL 12. Codes 13–15 go to RESET.
- Outputs are decoded from state (and Op where noted). Any output not listed for a state is 0.
- RESET: all outputs 0. Next state is FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=0000, PCSource=00. IRWrite=PCWrite=mem_ready. Moves to DECODE on mem_ready.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=0000, SignExtend=1. Next state by Op:
  - 0x23/0x2B → MEMADR
  - 0x00 → RTEX
  - 0x08/09/0C/0D/0E/0F → IMMEX
  - 0x04/0x05 → BRANCH
  - 0x02/0x03 → JUMP
  - any other Op → ILLEGAL
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=0000, SignExtend=1. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Held until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next is FETCH.
- MEMWR: MemWrite=1, IorD=1. Held until mem_ready, then FETCH.
- RTEX: ALUSrcA=1, ALUSrcB=00, ALUOp=1000. Next is ALUWB.
- IMMEX: ALUSrcA=1, ALUSrcB=10.
  - ALUOp per the table above.
  - SignExtend=1 for addi and lui; 0 for addiu, andi, ori, xori.
  - Next is ALUWB.
- ALUWB: RegWrite=1, MemtoReg=0, RegDst=(Op==0). Next is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=0100 (beq) or 0110 (bne), PCWriteCond=1, PCSource=01, BranchNot=(Op==0x05). Next is FETCH.
- JUMP: PCWrite=1, PCSource=10. For jal also RegWrite=1 and pcreg=1. Next is FETCH.
- ILLEGAL: illegal_op=1; no other writes (PC was already advanced in FETCH). Next is FETCH.

## Timing
- Cycle counts with zero wait states: lw 5; sw, R-type, immediate 4; beq, bne, j, jal 3; illegal 3.
- Each mem_ready-low cycle in FETCH, MEMRD or MEMWR adds one cycle. The strobes stay asserted and constant for the whole wait.
- Reset:
  - Asserting reset in any state, including wait states, sets state to RESET at the next edge.
  - Outputs in the reset-asserted cycle still reflect the old state.
  - The first FETCH is one cycle after reset deasserts.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.

## Configuration
- MEM_WAIT_EN defined: FETCH, MEMRD and MEMWR honour mem_ready as described.
- MEM_WAIT_EN undefined: mem_ready is ignored and treated as 1. Each memory state lasts exactly one cycle, and IRWrite and PCWrite are 1 throughout FETCH.

## Test plan
- Reset then mem_ready=1, Op=0x00 → state sequence 0,1,2,7,8,1; RegWrite=1 with RegDst=1 only in state 8; ALUOp=1000 in state 7.
- Op=0x23, mem_ready low 2 cycles in MEMRD (MEM_WAIT_EN) → states 1,2,3,4,4,4,5,1; MemRead=IorD=1 for all three MEMRD cycles; MemtoReg=1 in MEMWB.
- Op=0x05 → BRANCH with PCWriteCond=1, BranchNot=1, ALUOp=0110, PCSource=01; Op=0x04 gives BranchNot=0, ALUOp=0100.
- Op=0x03 → JUMP with PCWrite=1, PCSource=10, RegWrite=1, pcreg=1; Op=0x02 gives the same with RegWrite=pcreg=0.
- Op=0x3F → ILLEGAL, illegal_op high for exactly one cycle, then FETCH. Reset asserted during a MEMWR wait → RESET next edge, MemWrite=0 from then on.
